// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one ripple adder; one transaction in flight at a time.
// Define ADDER_ARB_ROUND_ROBIN_EN for alternating tie-break, otherwise requester 0 wins ties.
module adder_arbiter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W:0]   rsp_sum,
  input  logic         rsp_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         id_q, id_d;
  logic         last_grant_q, last_grant_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W:0]   rsp_sum_q, rsp_sum_d;

  logic         grant;
  logic         accept;
  logic [W-1:0] sum_bits;
  logic         carry_out;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      grant = ~last_grant_q;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  // Ripple chain over the latched operands, carry-in fixed at zero.
  always_comb begin
    logic c;
    c        = 1'b0;
    sum_bits = '0;
    for (int i = 0; i < W; i++) begin
      sum_bits[i] = a_q[i] ^ b_q[i] ^ c;
      c           = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    carry_out = c;
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = {carry_out, sum_bits};
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Response outputs are zero whenever no result is being offered.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_id_d    = 1'b0;
          rsp_sum_d   = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_sum_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: queued requester streams, arbitration model,
// and a negedge monitor comparing responses against plain a+b results.
module tb_adder_arbiter;
  localparam int W = 3;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_ready, busy;
  logic [W:0]   rsp_sum;

  always #5 clk = ~clk;

  adder_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  typedef struct {
    int id;
    int sum;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   q0a[$], q0b[$], q1a[$], q1b[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   acc0_cnt = 0, acc1_cnt = 0, taken0 = 0, taken1 = 0;
  bit   model_lg = 1'b1, model_busy = 1'b0;
  bit   prev_valid = 1'b0, prev_hold = 1'b0;
  int   hold_sum = 0, hold_id = 0;
  int   rdy_mode = 0;
  bit   gap_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Arbitration model and response monitor share one block so their order is fixed.
  always @(negedge clk) begin
    int   win;
    exp_t e;
    if (!rst_n) begin
      model_lg   = 1'b1;
      model_busy = 1'b0;
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      chk("busy", int'(busy), int'(model_busy));
      chk("one_ready", int'(req0_ready && req1_ready), 0);
      if (model_busy) begin
        chk("ready0_busy", int'(req0_ready), 0);
        chk("ready1_busy", int'(req1_ready), 0);
      end else if (req0_valid || req1_valid) begin
        if (req0_valid && req1_valid) win = RR_EN ? int'(!model_lg) : 0;
        else                          win = req0_valid ? 0 : 1;
        chk("grant", req1_ready ? 1 : (req0_ready ? 0 : -1), win);
        e.id      = win;
        e.sum     = (win == 1) ? q1a[0] + q1b[0] : q0a[0] + q0b[0];
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        model_lg   = win[0];
        model_busy = 1'b1;
        if (win == 1) acc1_cnt++;
        else          acc0_cnt++;
      end

      if (rsp_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else                   chk("latency", cyc, exp_q[0].acc_cyc + 2);
        end
        if (prev_hold) begin
          chk("hold_sum", int'(rsp_sum), hold_sum);
          chk("hold_id", int'(rsp_id), hold_id);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_no_expect", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", int'(rsp_id), e.id);
            chk("rsp_sum", int'(rsp_sum), e.sum);
          end
          model_busy = 1'b0;
        end
        prev_hold = !rsp_ready;
        hold_sum  = int'(rsp_sum);
        hold_id   = int'(rsp_id);
      end else begin
        chk("idle_sum", int'(rsp_sum), 0);
        chk("idle_id", int'(rsp_id), 0);
        if (prev_hold) chk("valid_dropped", 0, 1);
        prev_hold = 1'b0;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0_cnt != taken0) begin
      taken0++;
      void'(q0a.pop_front());
      void'(q0b.pop_front());
      req0_valid = 1'b0;
    end
    if (acc1_cnt != taken1) begin
      taken1++;
      void'(q1a.pop_front());
      void'(q1b.pop_front());
      req1_valid = 1'b0;
    end
    if (!req0_valid && q0a.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      req0_valid = 1'b1;
      req0_a     = W'(q0a[0]);
      req0_b     = W'(q0b[0]);
    end
    if (!req1_valid && q1a.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      req1_valid = 1'b1;
      req1_a     = W'(q1a[0]);
      req1_b     = W'(q1b[0]);
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q0a.size() > 0 || q1a.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_in_time", int'(n < max_cyc), 1);
  endtask

  task automatic push0(input int a, input int b);
    q0a.push_back(a);
    q0b.push_back(b);
  endtask

  task automatic push1(input int a, input int b);
    q1a.push_back(a);
    q1b.push_back(b);
  endtask

  initial begin
    int n;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_sum", int'(rsp_sum), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op, then overflow and zero on requester 1.
    push0(3, 5);
    drain(50);
    push1(7, 7);
    push1(0, 0);
    drain(50);

    // Continuous contention.
    for (int i = 0; i < 4; i++) begin
      push0(1, 2);
      push1(4, 4);
    end
    drain(200);

    // Backpressure: result held while both requesters wait.
    rdy_mode = 2;
    push0(2, 3);
    push1(1, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_rsp_seen", int'(rsp_valid), 1);
    repeat (5) begin
      step();
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_valid", int'(rsp_valid), 1);
    end
    rdy_mode = 0;
    step();
    step();
    chk("bp_release_idle", int'(busy), 0);
    drain(100);

    // Exhaustive operand pairs on both requesters with random backpressure.
    rdy_mode = 1;
    gap_en   = 1'b1;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        push0(a, b);
        push1(b, a);
      end
    drain(5000);

    // Random stream.
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 0) push0($urandom_range(0, 7), $urandom_range(0, 7));
      else                           push1($urandom_range(0, 7), $urandom_range(0, 7));
    end
    drain(2000);

    // Reset during CALC discards the transaction.
    rdy_mode = 0;
    gap_en   = 1'b0;
    push0(5, 6);
    n = 0;
    do begin
      step();
      n++;
    end while (!(busy && !rsp_valid) && n < 20);
    chk("calc_reached", int'(busy && !rsp_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sum", int'(rsp_sum), 0);
    chk("mid_rst_id", int'(rsp_id), 0);
    exp_q.delete();
    q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    taken0 = acc0_cnt;
    taken1 = acc1_cnt;
    rst_n  = 1'b1;
    repeat (3) step();
    chk("no_stale_rsp", int'(rsp_valid), 0);
    push0(1, 1);
    push1(2, 2);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
